// File: rtl/instr_obi_mem_slave.sv
// OBI instruction-memory responder for the IF stage: word-addressed memory behind a fixed-latency
// response pipeline, with grant back-pressure, an outstanding-transaction limit and error responses.
module instr_obi_mem_slave #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MEM_DEPTH       = 1024,
    parameter int unsigned RESP_LAT        = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_req_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,
    output logic                  instr_err_o,
    input  logic                  gnt_stall_i,
    input  logic                  load_we_i,
    input  logic [ADDR_WIDTH-1:0] load_addr_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    output logic [3:0]            outstanding_o
);

    localparam int unsigned IdxW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned WordW = ADDR_WIDTH - 2;
    localparam logic [WordW-1:0] DepthW = WordW'(MEM_DEPTH);
    localparam logic [3:0] MaxOut = 4'(MAX_OUTSTANDING);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [WordW-1:0]      rd_idx;
    logic [WordW-1:0]      ld_idx;
    logic                  rd_in_range;
    logic                  ld_in_range;
    logic [DATA_WIDTH-1:0] rd_word;

    logic [RESP_LAT-1:0]   vld_q;
    logic [RESP_LAT-1:0]   err_q;
    logic [DATA_WIDTH-1:0] data_q [RESP_LAT];

    logic [3:0]            outst_q;
    logic [3:0]            outst_d;

    logic                  unused_addr_bits;
    assign unused_addr_bits = ^{instr_addr_i[1:0], load_addr_i[1:0]};

    assign rd_idx      = instr_addr_i[ADDR_WIDTH-1:2];
    assign ld_idx      = load_addr_i[ADDR_WIDTH-1:2];
    assign rd_in_range = rd_idx < DepthW;
    assign ld_in_range = ld_idx < DepthW;
    assign rd_word     = rd_in_range ? mem[rd_idx[IdxW-1:0]] : '0;

    assign instr_gnt_o = rst_n & instr_req_i & ~gnt_stall_i & (outst_q < MaxOut);

    // Memory has no reset so a preload survives rst_n pulses.
    always_ff @(posedge clk) begin
        if (load_we_i && ld_in_range) begin
            mem[ld_idx[IdxW-1:0]] <= load_data_i;
        end
    end

    // Data is captured in the grant cycle, so later backdoor writes cannot alter it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < RESP_LAT; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= instr_gnt_o;
            err_q[0]  <= instr_gnt_o & ~rd_in_range;
            data_q[0] <= instr_gnt_o ? rd_word : '0;
            for (int i = 1; i < RESP_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                err_q[i]  <= err_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign instr_rvalid_o = vld_q[RESP_LAT-1];
    assign instr_err_o    = vld_q[RESP_LAT-1] & err_q[RESP_LAT-1];
    assign instr_rdata_o  = vld_q[RESP_LAT-1] ? data_q[RESP_LAT-1] : '0;

    always_comb begin
        outst_d = outst_q;
        if (instr_gnt_o && !instr_rvalid_o) begin
            outst_d = outst_q + 4'd1;
        end else if (!instr_gnt_o && instr_rvalid_o) begin
            outst_d = outst_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outst_q <= '0;
        end else begin
            outst_q <= outst_d;
        end
    end

    assign outstanding_o = outst_q;

endmodule
